serial_tx: RTL and testbench
============================

Name: serial_tx

Overview:
- Parallel-in, serial-out frame transmitter. It takes one DATA_W-bit word through a valid/ready handshake and shifts it out on a single line.
- Frame format: start bit (0), data LSB first, optional even parity, stop bit (1). Each bit is held for CLKS_PER_BIT clocks.
- Drives the serial line consumed by the team's serial receiver and registered sampling stages. The line idles high.

Parameters:
- DATA_W, 8, data word width in bits (legal range 1..16).
- CLKS_PER_BIT, 4, clock cycles per serial bit (legal range 1..256).
- PARITY_EN, 1, 1 = append an even-parity bit after the data; 0 = no parity bit.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- TxData  input  DATA_W  word to send; sampled only at acceptance.
- TxValid  input  1  producer has a word on TxData.
- TxReady  output  1  block can accept a word this cycle.
- TxOut  output  1  serial line, registered.
- Busy  output  1  frame in progress, registered.

Behaviour:
- All outputs are registered. There is no combinational path from inputs to outputs.
- Reset (sampled at a rising edge CLK with Reset=1):
  - state=IDLE, TxOut=1, TxReady=1, Busy=0.
  - Shift register, bit counter and baud counter are cleared.
- Reset has priority over all other events, including mid-frame. At the next edge the frame is aborted and TxOut returns to 1 with no stop bit emitted. A TxValid present in the same cycle as Reset is not accepted.
- States: IDLE, START, DATA, PARITY, STOP.
- Handshake:
  - A transfer occurs at the edge where TxValid=1 and TxReady=1.
  - TxReady=1 only in IDLE.
  - At acceptance, TxData is latched and the even-parity bit (XOR of all bits) is computed.
  - From the acceptance edge until the frame ends: TxReady=0, Busy=1.
  - TxData and TxValid are ignored while Busy=1.
- IDLE: TxOut=1. On acceptance -> START; the baud counter loads 0.
- START: TxOut=0 for CLKS_PER_BIT cycles, starting the cycle after the acceptance edge. Then -> DATA with bit index 0.
- DATA:
  - TxOut=word[index], LSB first, each bit held CLKS_PER_BIT cycles.
  - After bit DATA_W-1: -> PARITY if PARITY_EN=1, else -> STOP.
- PARITY: TxOut=parity for CLKS_PER_BIT cycles, then -> STOP.
- STOP:
  - TxOut=1 for CLKS_PER_BIT cycles, then -> IDLE.
  - Busy falls and TxReady rises at the same edge.
- Frame length is exactly (2+DATA_W+PARITY_EN)*CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle.
- Back-to-back:
  - TxValid held high gives acceptance at the first edge after TxReady returns to 1.
  - There is exactly one extra idle-high cycle between frames (the IDLE cycle).
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - Counter width is clog2(CLKS_PER_BIT)+1; no overflow is possible.
  - CLKS_PER_BIT=1 gives one bit per clock with no special casing.
- Bit counter is clog2(DATA_W)+1 wide. It is compared against DATA_W-1 with no wrap.
- TxOut changes only on bit boundaries and never glitches within a bit period.
- Out-of-range parameters are a compile-time error (elaboration assertion).

Test Plan:
- Reset then idle: hold Reset=1 for 2 cycles, release, TxValid=0 for 10 cycles -> TxOut=1, TxReady=1, Busy=0 throughout.
- Single frame 0xA5 (defaults):
  - Stimulus: TxValid=1 for one cycle.
  - Required TxOut, starting the next cycle, in 4-cycle bits: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1.
  - Required handshake: Busy=1 for 44 cycles, TxReady=0 for those cycles, then TxReady=1.
- Parity check: send 0x01 -> parity bit 1. Send 0x00 -> parity bit 0, and TxOut is low for 40 consecutive cycles.
- Back-to-back: TxValid held at 1 with 0x3C then 0xC3 -> second start bit begins exactly 1 cycle after the first frame's last stop cycle. TxData changes during frame 1 do not corrupt it.
- Reset mid-frame: assert Reset for 1 cycle during data bit 3 of 0xFF -> TxOut=1, Busy=0, TxReady=1 at the next edge. A subsequent 0x55 frame is bit-exact.
- Parameter sweep: CLKS_PER_BIT=1, PARITY_EN=0, DATA_W=4, send 0x9 -> TxOut sequence 0,1,0,0,1,1 on consecutive cycles; Busy high for exactly 6 cycles.

Source files
------------

// File: rtl/serial_tx.sv
// ---------------------------------------------------------------------------
// serial_tx
//   Parallel-in, serial-out frame transmitter. A DATA_W-bit word is accepted
//   through a valid/ready handshake and sent on a single line, which idles
//   high. Frame: start bit (0), data LSB first, optional even parity bit,
//   stop bit (1). Each bit is held for CLKS_PER_BIT clocks.
//
// Handshake: a word transfers at a rising CLK edge where TxValid=1 and
//   TxReady=1. TxReady is high only while idle. TxData and TxValid are
//   ignored while a frame is in progress.
//
// Ports:
//   CLK        in   system clock, rising edge
//   Reset      in   synchronous, active-high reset (aborts any frame)
//   TxData     in   [DATA_W] word to send, sampled only at acceptance
//   TxValid    in   producer has a word on TxData
//   TxReady    out  block can accept a word this cycle (registered)
//   TxOut      out  serial line (registered)
//   Busy       out  frame in progress (registered)
//   dbg_state  out  [3] current FSM state, for observation only
// ---------------------------------------------------------------------------
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [DATA_W-1:0] TxData,
    input  logic              TxValid,
    output logic              TxReady,
    output logic              TxOut,
    output logic              Busy,
    output logic [2:0]        dbg_state
);

    generate
        if (DATA_W < 1 || DATA_W > 16) begin : g_bad_data_w
            $error("serial_tx: DATA_W must be in 1..16");
        end
        if (CLKS_PER_BIT < 1 || CLKS_PER_BIT > 256) begin : g_bad_clks
            $error("serial_tx: CLKS_PER_BIT must be in 1..256");
        end
        if (PARITY_EN < 0 || PARITY_EN > 1) begin : g_bad_parity
            $error("serial_tx: PARITY_EN must be 0 or 1");
        end
    endgenerate

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int BIT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  baud, baud_n;
    logic [BIT_W-1:0]  idx, idx_n;
    logic [DATA_W-1:0] shreg, shreg_n, shreg_shift;
    logic              par, par_n;
    logic              tx_n, busy_n, ready_n;
    logic              bit_end;

    assign dbg_state   = state;
    assign bit_end     = (baud == BAUD_LAST);
    assign shreg_shift = shreg >> 1;

    // Outputs are computed one cycle ahead and registered, so TxOut only
    // moves on the edge that closes a bit period.
    always_comb begin
        state_n = state;
        baud_n  = baud;
        idx_n   = idx;
        shreg_n = shreg;
        par_n   = par;
        tx_n    = TxOut;
        busy_n  = Busy;
        ready_n = TxReady;

        if (state != IDLE) begin
            baud_n = bit_end ? '0 : baud + 1'b1;
        end

        case (state)
            IDLE: begin
                tx_n    = 1'b1;
                busy_n  = 1'b0;
                ready_n = 1'b1;
                if (TxValid && TxReady) begin
                    shreg_n = TxData;
                    par_n   = ^TxData;
                    baud_n  = '0;
                    idx_n   = '0;
                    state_n = START;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                    ready_n = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    idx_n   = '0;
                    tx_n    = shreg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx == BIT_LAST) begin
                        if (PARITY_EN != 0) begin
                            state_n = PARITY;
                            tx_n    = par;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        // Next bit is always the LSB of the shifted word.
                        idx_n   = idx + 1'b1;
                        shreg_n = shreg_shift;
                        tx_n    = shreg_shift[0];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_n = IDLE;
                    tx_n    = 1'b1;
                    busy_n  = 1'b0;
                    ready_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
                ready_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state   <= IDLE;
            baud    <= '0;
            idx     <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            TxOut   <= 1'b1;
            Busy    <= 1'b0;
            TxReady <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            idx     <= idx_n;
            shreg   <= shreg_n;
            par     <= par_n;
            TxOut   <= tx_n;
            Busy    <= busy_n;
            TxReady <= ready_n;
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_serial_tx
//   Bench for serial_tx. Two instances share one clock:
//     dut   : default parameters (DATA_W=8, CLKS_PER_BIT=4, PARITY_EN=1)
//     dut_s : DATA_W=4, CLKS_PER_BIT=1, PARITY_EN=0
//   Expected line/handshake values come from a frame model that lists the
//   frame's bits (start, data LSB first, even parity from a count of ones,
//   stop) and repeats each one CLKS_PER_BIT times.
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge after the rising edge that consumed the inputs.
// ---------------------------------------------------------------------------
module tb_serial_tx;

    localparam int M_W = 8;
    localparam int M_C = 4;
    localparam int M_P = 1;

    // ---------------- clock / reset block ----------------
    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // main instance signals
    logic           Reset, TxValid, TxReady, TxOut, Busy;
    logic [M_W-1:0] TxData;
    logic [2:0]     dbg_state;

    // small instance signals
    logic       s_rst, s_vld, s_rdy, s_out, s_busy;
    logic [3:0] s_data;
    logic [2:0] s_dbg;

    serial_tx #(.DATA_W(M_W), .CLKS_PER_BIT(M_C), .PARITY_EN(M_P)) dut (
        .CLK       (clk),
        .Reset     (Reset),
        .TxData    (TxData),
        .TxValid   (TxValid),
        .TxReady   (TxReady),
        .TxOut     (TxOut),
        .Busy      (Busy),
        .dbg_state (dbg_state)
    );

    serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut_s (
        .CLK       (clk),
        .Reset     (s_rst),
        .TxData    (s_data),
        .TxValid   (s_vld),
        .TxReady   (s_rdy),
        .TxOut     (s_out),
        .Busy      (s_busy),
        .dbg_state (s_dbg)
    );

    // ---------------- scoreboard ----------------
    // Each entry is {TxOut, TxReady, Busy} expected after one rising edge.
    logic [2:0] exp_q[$];
    logic       out_log[$];
    logic       busy_log[$];
    int         n_pass  = 0;
    int         n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    task automatic push_frame(input logic [M_W-1:0] w);
        logic b[$];
        int   ones;
        ones = 0;
        b.push_back(1'b0);
        for (int i = 0; i < M_W; i++) begin
            b.push_back(w[i]);
            ones += int'(w[i]);
        end
        if (M_P != 0) b.push_back((ones % 2) == 1);
        b.push_back(1'b1);
        foreach (b[i]) begin
            for (int j = 0; j < M_C; j++) exp_q.push_back({b[i], 1'b0, 1'b1});
        end
        // the single idle cycle that follows every frame
        exp_q.push_back(3'b110);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic rst, input logic vld, input logic [M_W-1:0] d, input string tag);
        logic [2:0] e;
        Reset   = rst;
        TxValid = vld;
        TxData  = d;
        @(posedge clk);
        @(negedge clk);
        out_log.push_back(TxOut);
        busy_log.push_back(Busy);
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL %s: expected queue empty", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, {29'd0, TxOut, TxReady, Busy}, {29'd0, e});
        end
    endtask

    // one frame: TxValid for the accepting cycle only, garbage data afterwards
    task automatic send_single(input logic [M_W-1:0] w, input string tag);
        int k;
        push_frame(w);
        step(1'b0, 1'b1, w, $sformatf("%s[0]", tag));
        k = 1;
        while (exp_q.size() > 0) begin
            step(1'b0, 1'b0, M_W'($urandom), $sformatf("%s[%0d]", tag, k));
            k++;
        end
    endtask

    function automatic int longest_low_run();
        int run, best;
        run = 0;
        best = 0;
        foreach (out_log[i]) begin
            run = (out_log[i] == 1'b0) ? run + 1 : 0;
            if (run > best) best = run;
        end
        return best;
    endfunction

    function automatic int count_busy();
        int n;
        n = 0;
        foreach (busy_log[i]) if (busy_log[i]) n++;
        return n;
    endfunction

    // ---------------- small-instance vector table ----------------
    typedef struct {
        logic       rst;
        logic       vld;
        logic [3:0] data;
        logic [2:0] exp;   // {TxOut, TxReady, Busy} after the edge
    } vec_t;

    vec_t tbl[23];

    function automatic vec_t mk(input logic r, input logic v, input logic [3:0] d,
                                input logic o, input logic rd, input logic b);
        vec_t t;
        t.rst  = r;
        t.vld  = v;
        t.data = d;
        t.exp  = {o, rd, b};
        return t;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        int k;
        logic [M_W-1:0] w;
        int gap;

        // reset held; valid alongside reset must not be accepted
        tbl[0]  = mk(1, 1, 4'hF, 1, 1, 0);
        tbl[1]  = mk(1, 0, 4'h0, 1, 1, 0);
        tbl[2]  = mk(0, 0, 4'h0, 1, 1, 0);
        // 0x9: 0,1,0,0,1,1 on consecutive cycles, Busy for 6 cycles
        tbl[3]  = mk(0, 1, 4'h9, 0, 0, 1);
        tbl[4]  = mk(0, 0, 4'h0, 1, 0, 1);
        tbl[5]  = mk(0, 0, 4'h0, 0, 0, 1);
        tbl[6]  = mk(0, 0, 4'h0, 0, 0, 1);
        tbl[7]  = mk(0, 0, 4'h0, 1, 0, 1);
        tbl[8]  = mk(0, 0, 4'h0, 1, 0, 1);
        tbl[9]  = mk(0, 0, 4'h0, 1, 1, 0);
        // 0x6 with TxValid held and data changing mid-frame
        tbl[10] = mk(0, 1, 4'h6, 0, 0, 1);
        tbl[11] = mk(0, 1, 4'hF, 0, 0, 1);
        tbl[12] = mk(0, 1, 4'hF, 1, 0, 1);
        tbl[13] = mk(0, 1, 4'hF, 1, 0, 1);
        tbl[14] = mk(0, 1, 4'hF, 0, 0, 1);
        tbl[15] = mk(0, 1, 4'hF, 1, 0, 1);
        tbl[16] = mk(0, 1, 4'hF, 1, 1, 0);
        // 0xA accepted after the single idle cycle, then reset mid-frame
        tbl[17] = mk(0, 1, 4'hA, 0, 0, 1);
        tbl[18] = mk(0, 0, 4'h0, 0, 0, 1);
        tbl[19] = mk(0, 0, 4'h0, 1, 0, 1);
        tbl[20] = mk(1, 0, 4'h0, 1, 1, 0);
        tbl[21] = mk(0, 0, 4'h0, 1, 1, 0);
        tbl[22] = mk(0, 0, 4'h0, 1, 1, 0);

        Reset = 1'b1; TxValid = 1'b0; TxData = '0;
        s_rst = 1'b1; s_vld = 1'b0; s_data = '0;
        @(negedge clk);

        // reset for 2 cycles, then 10 idle cycles
        repeat (2) exp_q.push_back(3'b110);
        step(1'b1, 1'b0, 8'h00, "reset[0]");
        step(1'b1, 1'b0, 8'h00, "reset[1]");
        check("dbg_state_known", {31'd0, $isunknown(dbg_state)}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(3'b110);
            step(1'b0, 1'b0, M_W'($urandom), $sformatf("idle[%0d]", i));
        end

        // single frame 0xA5
        out_log.delete(); busy_log.delete();
        send_single(8'hA5, "a5");
        check("a5_busy_len", count_busy(), 44);

        // parity bit 1 / parity bit 0
        send_single(8'h01, "p01");
        out_log.delete(); busy_log.delete();
        send_single(8'h00, "p00");
        check("p00_low_run", longest_low_run(), 40);

        // back-to-back with TxValid held; frame 1 data scrambled while busy
        push_frame(8'h3C);
        push_frame(8'hC3);
        k = 0;
        while (exp_q.size() > 0) begin
            w = (k == 0) ? 8'h3C : (k == 45) ? 8'hC3 : M_W'($urandom);
            step(1'b0, (k <= 45), w, $sformatf("b2b[%0d]", k));
            k++;
        end

        // reset during data bit 3 of 0xFF, valid present with reset
        push_frame(8'hFF);
        while (exp_q.size() > 18) void'(exp_q.pop_back());
        for (int i = 0; i < 18; i++)
            step(1'b0, (i == 0), 8'hFF, $sformatf("rst_mid[%0d]", i));
        exp_q.push_back(3'b110);
        step(1'b1, 1'b1, 8'hAA, "rst_mid_abort");
        exp_q.push_back(3'b110);
        step(1'b0, 1'b0, 8'h00, "rst_mid_after");
        send_single(8'h55, "x55");

        // randomized frames with random idle gaps
        for (int f = 0; f < 20; f++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                exp_q.push_back(3'b110);
                step(1'b0, 1'b0, M_W'($urandom), $sformatf("rnd%0d_gap", f));
            end
            w = M_W'($urandom_range(0, 255));
            push_frame(w);
            step(1'b0, 1'b1, w, $sformatf("rnd%0d[0]", f));
            k = 1;
            while (exp_q.size() > 0) begin
                step(1'b0, 1'($urandom), M_W'($urandom), $sformatf("rnd%0d[%0d]", f, k));
                k++;
            end
        end
        Reset = 1'b0; TxValid = 1'b0;

        // small instance, table-driven
        for (int i = 0; i < 23; i++) begin
            s_rst  = tbl[i].rst;
            s_vld  = tbl[i].vld;
            s_data = tbl[i].data;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("tbl[%0d]", i), {29'd0, s_out, s_rdy, s_busy}, {29'd0, tbl[i].exp});
        end
        check("s_dbg_state_known", {31'd0, $isunknown(s_dbg)}, 32'd0);

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
